bcd_digit_split8: RTL and testbench

Sequential binary-to-BCD converter that turns a 27-bit unsigned result (for example the multiplier product) into eight 8421-BCD digits. It drives the eight `seg0`–`seg7` digit inputs of the eight-digit seven-segment scan driver. It uses shift-add-3 (double dabble) over 27 cycles. The digit outputs are registered and held stable between conversions, so the scan driver never displays a partial result.

---
 rtl/bcd_digit_split8_if.sv | 22 ++
 rtl/bcd_digit_split8.sv | 130 +++++++++++++
 tb/tb_bcd_digit_split8.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_digit_split8_if.sv
// Handshake and digit bus between a result producer and the binary-to-BCD converter.
// The converter drives busy/done/ovf and the eight registered digits seg0..seg7.
interface bcd_digit_split8_if #(
  parameter int unsigned BIN_W = 27
) ();
  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [3:0]       seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

  modport master (
    output start, bin,
    input  busy, done, ovf, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7
  );

  modport slave (
    input  start, bin,
    output busy, done, ovf, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7
  );
endinterface

// File: rtl/bcd_digit_split8.sv
// Sequential 27-bit binary to 8-digit BCD converter (double dabble, 27 cycles per result).
// Optional leading-zero blanking when BCD_LZ_BLANK_EN is defined.
module bcd_digit_split8 #(
  parameter int unsigned BIN_W = 27,
  parameter int unsigned NDIG  = 8
) (
  input logic               clk,
  input logic               rst_n,
  bcd_digit_split8_if.slave bus
);

  localparam int unsigned SW = 4 * NDIG;
  localparam logic [4:0]  LastCnt = 5'(BIN_W - 1);

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [SW-1:0]      scratch_q, scratch_d;
  logic               ovf_int_q, ovf_int_d;
  logic [SW-1:0]      digits_q, digits_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [SW-1:0]      adj;
  logic [SW+BIN_W-1:0] shifted;
  logic [SW-1:0]      scratch_nxt;
  logic [BIN_W-1:0]   shift_nxt;
  logic [SW-1:0]      fin;
  logic               lead;

  // One double-dabble step: add 3 to every nibble >= 5, then shift the pair left.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    shifted     = {adj, shift_q} << 1;
    scratch_nxt = shifted[SW+BIN_W-1:BIN_W];
    shift_nxt   = shifted[BIN_W-1:0];
  end

  // Digits loaded on the completing edge, derived from the final scratch value.
  always_comb begin
    fin  = scratch_nxt;
    lead = 1'b1;
    if (ovf_int_q) begin
      fin = {NDIG{4'hE}};
    end
`ifdef BCD_LZ_BLANK_EN
    else begin
      for (int i = int'(NDIG) - 1; i > 0; i--) begin
        if (lead && (fin[4*i +: 4] == 4'd0)) fin[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    ovf_int_d = ovf_int_q;
    digits_d  = digits_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StConv;
          shift_d   = bus.bin;
          scratch_d = '0;
          cnt_d     = '0;
          ovf_int_d = (bus.bin > BIN_W'(99_999_999));
        end
      end
      StConv: begin
        scratch_d = scratch_nxt;
        shift_d   = shift_nxt;
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == LastCnt) begin
          state_d  = StIdle;
          cnt_d    = '0;
          digits_d = fin;
          ovf_d    = ovf_int_q;
          done_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      ovf_int_q <= 1'b0;
      digits_q  <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      ovf_int_q <= ovf_int_d;
      digits_q  <= digits_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q == StConv);
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.seg0 = digits_q[3:0];
  assign bus.seg1 = digits_q[7:4];
  assign bus.seg2 = digits_q[11:8];
  assign bus.seg3 = digits_q[15:12];
  assign bus.seg4 = digits_q[19:16];
  assign bus.seg5 = digits_q[23:20];
  assign bus.seg6 = digits_q[27:24];
  assign bus.seg7 = digits_q[31:28];

endmodule

// File: tb/tb_bcd_digit_split8.sv
// Scoreboard bench for bcd_digit_split8: a driver predicts accepted conversions from decimal
// arithmetic and queues them; a negedge monitor checks done timing, digits, ovf and busy.
module tb_bcd_digit_split8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  bcd_digit_split8_if #(.BIN_W(27)) bus ();

  bcd_digit_split8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] segs;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          next_free = 0;
  int          last_accept = -100;
  logic [31:0] cur_segs = '0;
  logic        cur_ovf = 1'b0;
  logic        prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: decimal digits by division; over-range shows all E.
  function automatic logic [31:0] ref_segs(input int unsigned v);
    logic [31:0] r;
    int unsigned p;
    int          n;
    int unsigned t;
    r = '0;
    if (v > 99_999_999) return {8{4'hE}};
    p = 1;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
`ifdef BCD_LZ_BLANK_EN
    n = 1;
    t = v / 10;
    while (t > 0) begin
      n++;
      t = t / 10;
    end
    for (int i = n; i < 8; i++) r[4*i +: 4] = 4'hF;
`else
    n = 0;
    t = 0;
`endif
    return r;
  endfunction

  function automatic logic [31:0] dut_segs();
    return {bus.seg7, bus.seg6, bus.seg5, bus.seg4, bus.seg3, bus.seg2, bus.seg1, bus.seg0};
  endfunction

  // One cycle of stimulus; start is predicted to be accepted only when the block is idle.
  task automatic tick(input logic s, input logic [26:0] v);
    exp_t e;
    @(negedge clk);
    #1;
    bus.start = s;
    bus.bin   = v;
    if (s && rst_n && (cyc + 1 >= next_free)) begin
      e.segs = ref_segs(32'(v));
      e.ovf  = (v > 27'd99_999_999);
      e.cyc  = cyc + 1 + 27;
      q.push_back(e);
      last_accept = cyc + 1;
      next_free   = cyc + 1 + 28;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 27'($urandom));
  endtask

  task automatic pulse(input logic [26:0] v);
    tick(1'b1, v);
    tick(1'b0, 27'($urandom));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.done) begin
        chk("done_single", 64'(prev_done), 64'd0);
        if (q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("done_latency", 64'(cyc), 64'(e.cyc));
          chk("result_digits", 64'(dut_segs()), 64'(e.segs));
          chk("result_ovf", 64'(bus.ovf), 64'(e.ovf));
          cur_segs = e.segs;
          cur_ovf  = e.ovf;
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        chk("missing_done", 64'd0, 64'd1);
        void'(q.pop_front());
      end
      chk("busy", 64'(bus.busy),
          64'((cyc >= last_accept) && (cyc <= last_accept + 26)));
      chk("held_digits", 64'(dut_segs()), 64'(cur_segs));
      chk("held_ovf", 64'(bus.ovf), 64'(cur_ovf));
      prev_done = bus.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_ovf"}, 64'(bus.ovf), 64'd0);
    chk({tag, "_digits"}, 64'(dut_segs()), 64'd0);
  endtask

  initial begin
    logic [26:0] v;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);
    check_reset_outputs("post_reset");

    // Directed values from the test plan.
    pulse(27'd12_345_678);  idle(30);
    pulse(27'd305);         idle(30);
    pulse(27'd99_999_999);  idle(30);
    pulse(27'd100_000_000); idle(30);
    pulse(27'd0);           idle(30);
    pulse(27'd134_217_727); idle(30);

    // Handshake: second start while busy ignored, start in done cycle accepted.
    pulse(27'd42);
    idle(8);
    pulse(27'd7);
    while (cyc + 1 < next_free) tick(1'b0, 27'($urandom));
    tick(1'b1, 27'd7);
    tick(1'b0, 27'd0);
    idle(30);

    // Continuous start with bin changing every cycle.
    for (int i = 0; i < 90; i++) tick(1'b1, 27'($urandom_range(0, 99_999_999)));
    idle(30);

    // Reset mid-conversion.
    pulse(27'd5555);
    idle(11);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    next_free   = 0;
    last_accept = -100;
    cur_segs    = '0;
    cur_ovf     = 1'b0;
    #1;
    check_reset_outputs("midreset");
    idle(2);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    pulse(27'd87_654_321);
    idle(30);

    // Random values, gaps and stray starts.
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) v = 27'($urandom);
      else v = 27'($urandom_range(0, 99_999_999));
      pulse(v);
      if ($urandom_range(0, 1) == 1) begin
        idle($urandom_range(0, 20));
        pulse(27'($urandom));
      end
      idle($urandom_range(0, 35));
    end

    idle(40);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
